// File: rtl/bitwise_logic_unit.sv
// -----------------------------------------------------------------------------
// bitwise_logic_unit
//
// Registered two-operand bitwise logic unit. Eight run-time selectable ops,
// one-shot beats or multi-beat folds (reductions), and a single-entry output
// register with valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake; beat accepted when both are high
//   in_a, in_b            operands (WIDTH bits)
//   in_op                 op select: AND OR XOR NAND NOR XNOR ANDN PASS
//   in_acc                1 = beat starts/continues a fold, 0 = one-shot
//   in_last               final beat of a fold
//   out_valid / out_ready output handshake; result taken when both are high
//   out_z                 result (WIDTH bits)
//   out_zero              out_z == 0
//   out_count             beats folded into the result, saturating at 255
// -----------------------------------------------------------------------------
module bitwise_logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic             out_zero,
  output logic [7:0]       out_count
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_ANDN = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FOLD = 1'b1
  } state_e;

  function automatic logic [WIDTH-1:0] apply_op(input op_e op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    r = '0;
    case (op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_NAND: r = ~(x & y);
      OP_NOR:  r = ~(x | y);
      OP_XNOR: r = ~(x ^ y);
      OP_ANDN: r = x & ~y;
      OP_PASS: r = x;
      default: r = x;
    endcase
    return r;
  endfunction

  state_e           state_q,     state_d;
  op_e              op_q,        op_d;
  logic [WIDTH-1:0] acc_q,       acc_d;
  logic [7:0]       cnt_q,       cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_z_q,     out_z_d;
  logic             out_zero_q,  out_zero_d;
  logic [7:0]       out_count_q, out_count_d;

  logic             accept;
  logic             take;
  logic             load_out;
  logic [WIDTH-1:0] res;
  logic [7:0]       cnt_inc;

  // A new beat may enter whenever the output slot is empty or is being
  // drained on this same edge, so results are never dropped or reordered.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign take     = out_valid_q && out_ready;
  assign cnt_inc  = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    op_d        = op_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    load_out    = 1'b0;
    res         = '0;
    out_z_d     = out_z_q;
    out_zero_d  = out_zero_q;
    out_count_d = out_count_q;

    if (accept) begin
      if (state_q == ST_IDLE) begin
        res = apply_op(op_e'(in_op), in_a, in_b);
        if (!in_acc) begin
          load_out    = 1'b1;
          out_count_d = 8'd1;
        end else begin
          op_d  = op_e'(in_op);
          acc_d = res;
          cnt_d = 8'd1;
          if (in_last) begin
            load_out    = 1'b1;
            out_count_d = 8'd1;
          end else begin
            state_d = ST_FOLD;
          end
        end
      end else begin
        // Fold continuation: the running value replaces operand A's role and
        // in_a supplies the new operand; in_b/in_op/in_acc are don't-cares.
        res   = apply_op(op_q, acc_q, in_a);
        acc_d = res;
        cnt_d = cnt_inc;
        if (in_last) begin
          load_out    = 1'b1;
          out_count_d = cnt_inc;
          state_d     = ST_IDLE;
        end
      end
    end

    if (load_out) begin
      out_z_d    = res;
      out_zero_d = (res == '0);
    end

    // A load on the same edge as a take keeps the slot full with new data.
    out_valid_d = load_out ? 1'b1 : (take ? 1'b0 : out_valid_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_AND;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_z_q     <= '0;
      out_zero_q  <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_z_q     <= out_z_d;
      out_zero_q  <= out_zero_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_z     = out_z_q;
  assign out_zero  = out_zero_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// -----------------------------------------------------------------------------
// tb_bitwise_logic_unit
//
// Directed bench for bitwise_logic_unit. An 8-bit instance covers reset,
// backpressure, folds, reset mid-fold and count saturation; a 2-bit instance
// runs the exhaustive one-shot sweep over all ops. Inputs change on the
// falling edge and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_bitwise_logic_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 8-bit instance
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [2:0] in_op = '0;
  logic       in_acc = 1'b0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_z;
  logic       out_zero;
  logic [7:0] out_count;

  bitwise_logic_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_zero(out_zero), .out_count(out_count)
  );

  // 2-bit instance
  logic       w2_in_valid = 1'b0;
  logic       w2_in_ready;
  logic [1:0] w2_in_a = '0;
  logic [1:0] w2_in_b = '0;
  logic [2:0] w2_in_op = '0;
  logic       w2_in_acc = 1'b0;
  logic       w2_in_last = 1'b0;
  logic       w2_out_valid;
  logic       w2_out_ready = 1'b1;
  logic [1:0] w2_out_z;
  logic       w2_out_zero;
  logic [7:0] w2_out_count;

  bitwise_logic_unit #(.WIDTH(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w2_in_valid), .in_ready(w2_in_ready),
    .in_a(w2_in_a), .in_b(w2_in_b), .in_op(w2_in_op), .in_acc(w2_in_acc),
    .in_last(w2_in_last),
    .out_valid(w2_out_valid), .out_ready(w2_out_ready),
    .out_z(w2_out_z), .out_zero(w2_out_zero), .out_count(w2_out_count)
  );

  // Reference op table for the sweep.
  function automatic logic [1:0] ref_op2(input logic [2:0] op,
                                         input logic [1:0] x,
                                         input logic [1:0] y);
    case (op)
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b010:  return x ^ y;
      3'b011:  return ~(x & y);
      3'b100:  return ~(x | y);
      3'b101:  return ~(x ^ y);
      3'b110:  return x & ~y;
      default: return x;
    endcase
  endfunction

  task automatic drive_beat(input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] op, input logic acc,
                            input logic last);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_acc   = acc;
    in_last  = last;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_z !== 8'h00) begin errors++; $display("FAIL reset_z got %h want 00", out_z); end
    checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b want 0", out_zero); end
    checks++; if (out_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", out_count); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_after got %b want 0", out_valid); end
  endtask

  task automatic test_sweep_w2();
    logic [1:0] exp_z;
    logic [3:0] v;
    logic       have_prev;
    have_prev = 1'b0;
    exp_z = '0;
    for (int op = 0; op < 8; op++) begin
      for (int i = 0; i < 16; i++) begin
        v = i[3:0];
        w2_in_valid = 1'b1;
        w2_in_op    = op[2:0];
        w2_in_a     = v[3:2];
        w2_in_b     = v[1:0];
        w2_in_acc   = 1'b0;
        w2_in_last  = 1'b0;
        @(negedge clk);
        exp_z = ref_op2(op[2:0], v[3:2], v[1:0]);
        checks++; if (w2_out_valid !== 1'b1) begin errors++; $display("FAIL sweep_valid op=%0d ab=%0d got %b want 1", op, i, w2_out_valid); end
        checks++; if (w2_out_z !== exp_z) begin errors++; $display("FAIL sweep_z op=%0d ab=%0d got %b want %b", op, i, w2_out_z, exp_z); end
        checks++; if (w2_out_zero !== (exp_z == 2'b00)) begin errors++; $display("FAIL sweep_zero op=%0d ab=%0d got %b want %b", op, i, w2_out_zero, (exp_z == 2'b00)); end
        checks++; if (w2_out_count !== 8'd1) begin errors++; $display("FAIL sweep_count op=%0d ab=%0d got %0d want 1", op, i, w2_out_count); end
        have_prev = 1'b1;
      end
    end
    w2_in_valid = 1'b0;
    @(negedge clk);
    checks++; if (have_prev && w2_out_valid !== 1'b0) begin errors++; $display("FAIL sweep_drain got %b want 0", w2_out_valid); end
    // Explicit hand-worked cases: AND 11,10 -> 10 ; NOR 00,00 -> 11
    w2_in_valid = 1'b1; w2_in_op = 3'b000; w2_in_a = 2'b11; w2_in_b = 2'b10;
    @(negedge clk);
    checks++; if (w2_out_z !== 2'b10) begin errors++; $display("FAIL sweep_and_example got %b want 10", w2_out_z); end
    w2_in_op = 3'b100; w2_in_a = 2'b00; w2_in_b = 2'b00;
    @(negedge clk);
    w2_in_valid = 1'b0;
    checks++; if (w2_out_z !== 2'b11 || w2_out_zero !== 1'b0) begin errors++; $display("FAIL sweep_nor_example got %b zero %b want 11 zero 0", w2_out_z, w2_out_zero); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive_beat(8'hF0, 8'h0F, 3'b010, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_z !== 8'hFF) begin errors++; $display("FAIL bp_first got valid %b z %h want 1 ff", out_valid, out_z); end
    drive_beat(8'hAA, 8'hAA, 3'b010, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      checks++; if (out_z !== 8'hFF || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold got valid %b z %h want 1 ff", out_valid, out_z); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || out_z !== 8'hFF) begin errors++; $display("FAIL bp_release got ready %b z %h want 1 ff", in_ready, out_z); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_z !== 8'h00 || out_zero !== 1'b1) begin errors++; $display("FAIL bp_second got valid %b z %h zero %b want 1 00 1", out_valid, out_z, out_zero); end
    checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL bp_second_count got %0d want 1", out_count); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_fold_and();
    drive_beat(8'hFF, 8'h7E, 3'b000, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fold_beat1_no_out got %b want 0", out_valid); end
    // op, b and acc deliberately changed: must be ignored inside a fold
    drive_beat(8'h3C, 8'h00, 3'b111, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fold_beat2_no_out got %b want 0", out_valid); end
    drive_beat(8'h1F, 8'hFF, 3'b010, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_z !== 8'h1C) begin errors++; $display("FAIL fold_and_z got valid %b z %h want 1 1c", out_valid, out_z); end
    checks++; if (out_count !== 8'd3) begin errors++; $display("FAIL fold_and_count got %0d want 3", out_count); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fold_single_output got %b want 0", out_valid); end
  endtask

  task automatic test_single_beat_fold();
    drive_beat(8'h01, 8'h80, 3'b001, 1'b1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_z !== 8'h81 || out_count !== 8'd1) begin errors++; $display("FAIL single_fold got valid %b z %h count %0d want 1 81 1", out_valid, out_z, out_count); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_fold();
    drive_beat(8'h55, 8'h0F, 3'b010, 1'b1, 1'b0);
    @(negedge clk);
    drive_beat(8'h33, 8'h00, 3'b010, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_z !== 8'h00 || out_count !== 8'd0) begin errors++; $display("FAIL rst_mid_data got z %h count %0d want 00 0", out_z, out_count); end
    checks++; if (out_valid !== 1'b0 || out_zero !== 1'b0) begin errors++; $display("FAIL rst_mid_flags got valid %b zero %b want 0 0", out_valid, out_zero); end
    @(negedge clk);
    rst_n = 1'b1;
    drive_beat(8'h0F, 8'h03, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_z !== 8'h03 || out_count !== 8'd1) begin errors++; $display("FAIL rst_mid_next got valid %b z %h count %0d want 1 03 1", out_valid, out_z, out_count); end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    logic [7:0] a;
    int         early_out;
    early_out = 0;
    for (int i = 0; i < 300; i++) begin
      a = 8'h01 << (i % 8);
      drive_beat(a, 8'h00, 3'b001, 1'b1, (i == 299));
      @(negedge clk);
      if (i != 299 && out_valid) early_out++;
    end
    in_valid = 1'b0;
    checks++; if (early_out !== 0) begin errors++; $display("FAIL sat_early_out got %0d want 0", early_out); end
    checks++; if (out_valid !== 1'b1 || out_z !== 8'hFF) begin errors++; $display("FAIL sat_z got valid %b z %h want 1 ff", out_valid, out_z); end
    checks++; if (out_count !== 8'd255) begin errors++; $display("FAIL sat_count got %0d want 255", out_count); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sweep_w2();
    test_backpressure();
    test_fold_and();
    test_single_beat_fold();
    test_reset_mid_fold();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
